// File: rtl/adc_xy_pkg.sv
// Shared types and default timing for the X/Y ADC capture path.
package adc_xy_pkg;

    typedef enum logic [2:0] {
        CAP_OFF   = 3'd0,
        CAP_WAKE  = 3'd1,
        CAP_PRIME = 3'd2,
        CAP_RUN   = 3'd3,
        CAP_DRAIN = 3'd4
    } cap_state_t;

    // Also used by the capture datapath to size its color delay line.
    localparam int unsigned ADC_PIPE_CYCLES = 9;
    localparam int unsigned ADC_WAKE_CYCLES = 64;

endpackage

// File: rtl/adc_xy_capture_ctrl_sat_counter.sv
// Saturating up-counter; clear has priority over a same-cycle increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/adc_xy_capture_ctrl.sv
// ADC power/prime/drain sequencer for the X/Y capture path, with FIFO
// backpressure gating, saturating sample/drop statistics and beam-idle flag.
module adc_xy_capture_ctrl
    import adc_xy_pkg::*;
#(
    parameter int unsigned WAKE_CYCLES = ADC_WAKE_CYCLES,
    parameter int unsigned PIPE_CYCLES = ADC_PIPE_CYCLES,
    parameter int unsigned IDLE_CYCLES = 4096,
    parameter int unsigned CNT_BITS    = 16
) (
    input  logic                adc_clk,
    input  logic                reset,
    input  logic                run_req,
    input  logic                pixel_lit,
    input  logic                data_changed,
    input  logic                fifo_almost_full,
    input  logic                cnt_clr,
    output logic                adc_pwdn,
    output logic                adc_oe_n,
    output logic                capture_en,
    output logic                running,
    output logic                beam_idle,
    output logic [CNT_BITS-1:0] sample_cnt,
    output logic [CNT_BITS-1:0] drop_cnt
);

    localparam int unsigned MAX_CYC = (WAKE_CYCLES > PIPE_CYCLES) ? WAKE_CYCLES : PIPE_CYCLES;
    localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned IDLE_W  = $clog2(IDLE_CYCLES + 1);

    localparam logic [TMR_W-1:0]  WAKE_LOAD = TMR_W'(WAKE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  PIPE_LOAD = TMR_W'(PIPE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(IDLE_CYCLES);

    cap_state_t        state;
    logic [TMR_W-1:0]  timer;
    logic [IDLE_W-1:0] idle_ctr;
    logic [IDLE_W-1:0] idle_nxt;
    logic              in_window;
    logic              ev;
    logic              sample_inc;
    logic              drop_inc;

    // Sequencer; registered outputs are updated on the same edge as the state.
    always_ff @(posedge adc_clk) begin
        if (reset) begin
            state    <= CAP_OFF;
            timer    <= '0;
            adc_pwdn <= 1'b1;
            adc_oe_n <= 1'b1;
            running  <= 1'b0;
        end else begin
            case (state)
                CAP_OFF: begin
                    if (run_req) begin
                        state    <= CAP_WAKE;
                        timer    <= WAKE_LOAD;
                        adc_pwdn <= 1'b0;
                        adc_oe_n <= 1'b0;
                    end
                end
                CAP_WAKE: begin
                    if (!run_req) begin
                        state    <= CAP_OFF;
                        timer    <= '0;
                        adc_pwdn <= 1'b1;
                        adc_oe_n <= 1'b1;
                    end else if (timer == '0) begin
                        state <= CAP_PRIME;
                        timer <= PIPE_LOAD;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                CAP_PRIME: begin
                    if (!run_req) begin
                        state    <= CAP_OFF;
                        timer    <= '0;
                        adc_pwdn <= 1'b1;
                        adc_oe_n <= 1'b1;
                    end else if (timer == '0) begin
                        state   <= CAP_RUN;
                        running <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                CAP_RUN: begin
                    if (!run_req) begin
                        state   <= CAP_DRAIN;
                        timer   <= PIPE_LOAD;
                        running <= 1'b0;
                    end
                end
                CAP_DRAIN: begin
                    // A renewed request resumes capture without cycling ADC power.
                    if (run_req) begin
                        state   <= CAP_RUN;
                        timer   <= '0;
                        running <= 1'b1;
                    end else if (timer == '0) begin
                        state    <= CAP_OFF;
                        adc_pwdn <= 1'b1;
                        adc_oe_n <= 1'b1;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                default: begin
                    state    <= CAP_OFF;
                    timer    <= '0;
                    adc_pwdn <= 1'b1;
                    adc_oe_n <= 1'b1;
                    running  <= 1'b0;
                end
            endcase
        end
    end

    // Backpressure acts in the same cycle; DRAIN still lands in-flight samples.
    assign in_window  = (state == CAP_RUN) || (state == CAP_DRAIN);
    assign capture_en = in_window && !fifo_almost_full;
    assign ev         = pixel_lit && data_changed;
    assign sample_inc = capture_en && ev;
    assign drop_inc   = in_window && fifo_almost_full && ev;

    sat_counter #(.WIDTH(CNT_BITS)) u_sample_cnt (
        .clk   (adc_clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (sample_inc),
        .count (sample_cnt)
    );

    sat_counter #(.WIDTH(CNT_BITS)) u_drop_cnt (
        .clk   (adc_clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (drop_inc),
        .count (drop_cnt)
    );

    // Unlit-run length, saturating at IDLE_CYCLES.
    always_comb begin
        idle_nxt = '0;
        if ((state == CAP_RUN) && !pixel_lit) begin
            idle_nxt = (idle_ctr == IDLE_MAX) ? idle_ctr : idle_ctr + IDLE_W'(1);
        end
    end

    always_ff @(posedge adc_clk) begin
        if (reset) begin
            idle_ctr  <= '0;
            beam_idle <= 1'b0;
        end else begin
            idle_ctr  <= idle_nxt;
            beam_idle <= (idle_nxt == IDLE_MAX);
        end
    end

endmodule
